// File: rtl/bram_search_engine_pkg.sv
// Shared types for the BRAM search engine: FSM state encoding and scan modes.
package search_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic MODE_FIRST = 1'b0;
    localparam logic MODE_ALL   = 1'b1;

endpackage

// File: rtl/bram_search_engine_if.sv
// Host access and search control/result bundle for bram_search_engine.
interface bram_search_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  cs;
    logic                  we;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  start;
    logic [DATA_WIDTH-1:0] key;
    logic                  mode;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [ADDR_WIDTH-1:0] position;
    logic [ADDR_WIDTH:0]   match_count;

    modport master (
        output cs, we, oe, address, din, start, key, mode,
        input  dout, busy, done, found, position, match_count
    );

    modport slave (
        input  cs, we, oe, address, din, start, key, mode,
        output dout, busy, done, found, position, match_count
    );
endinterface

// File: rtl/bram_search_engine_sp_core.sv
// Single-port RAM with write enable and registered read enable; infers as block RAM.
module bram_sp_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // No reset on the array or the read register so the tools map both into BRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/bram_search_engine.sv
// Block RAM with host port and a sequential key search (first-match or count-all).
module bram_search_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_search_engine_if.slave  bus
);
    import search_pkg::*;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_WIDE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] key_reg;
    logic                  mode_reg;
    logic [ADDR_WIDTH:0]   scan_addr_reg;
    logic                  cmp_valid_reg;
    logic [ADDR_WIDTH-1:0] cmp_addr_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  found_reg;
    logic [ADDR_WIDTH-1:0] position_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  sel_reg;
    logic [DATA_WIDTH-1:0] dout_hold_reg;

    logic                  idle, scanning, host_wr, host_rd, scan_issue, hit, last_cmp;
    logic                  ram_we, ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign idle       = (state_reg == S_IDLE);
    assign scanning   = (state_reg == S_SCAN);
    assign host_wr    = idle && bus.cs && bus.we && !bus.oe;
    assign host_rd    = idle && bus.cs && !bus.we && bus.oe;
    // The scan address has one spare bit so the read stream stops after DEPTH words.
    assign scan_issue = scanning && !scan_addr_reg[ADDR_WIDTH];
    assign hit        = cmp_valid_reg && (ram_rdata == key_reg);
    assign last_cmp   = cmp_valid_reg && (cmp_addr_reg == LAST_ADDR);

    assign ram_we   = host_wr;
    assign ram_re   = host_rd || scan_issue;
    assign ram_addr = scanning ? scan_addr_reg[ADDR_WIDTH-1:0] : bus.address;

    bram_sp_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.din),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_SCAN;
            S_SCAN:   if ((hit && mode_reg == MODE_FIRST) || last_cmp) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg       <= '0;
            mode_reg      <= MODE_FIRST;
            scan_addr_reg <= '0;
            cmp_valid_reg <= 1'b0;
            cmp_addr_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            found_reg     <= 1'b0;
            position_reg  <= '0;
            count_reg     <= '0;
            sel_reg       <= 1'b0;
            dout_hold_reg <= '0;
        end else begin
            busy_reg <= (state_next == S_SCAN);
            done_reg <= (state_next == S_FINISH);
            unique case (state_reg)
                S_IDLE: begin
                    if (host_rd) begin
                        sel_reg <= 1'b1;
                    end
                    if (bus.start) begin
                        key_reg       <= bus.key;
                        mode_reg      <= bus.mode;
                        scan_addr_reg <= '0;
                        cmp_valid_reg <= 1'b0;
                        found_reg     <= 1'b0;
                        position_reg  <= '0;
                        count_reg     <= '0;
                    end
                end
                S_SCAN: begin
                    // Park the last host read value before the scan overwrites the RAM read register.
                    if (sel_reg) begin
                        dout_hold_reg <= ram_rdata;
                        sel_reg       <= 1'b0;
                    end
                    if (scan_issue) begin
                        scan_addr_reg <= scan_addr_reg + ONE_WIDE;
                    end
                    cmp_valid_reg <= scan_issue;
                    cmp_addr_reg  <= scan_addr_reg[ADDR_WIDTH-1:0];
                    if (hit) begin
                        count_reg <= count_reg + ONE_WIDE;
                        if (!found_reg) begin
                            found_reg    <= 1'b1;
                            position_reg <= cmp_addr_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout        = sel_reg ? ram_rdata : dout_hold_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.found       = found_reg;
    assign bus.position    = position_reg;
    assign bus.match_count = count_reg;
endmodule

// File: tb/tb_bram_search_engine.sv
// Self-checking bench for bram_search_engine against a behavioural scan model.
module tb_bram_search_engine;
    import search_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_search_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    bram_search_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] model [DEPTH];

    // Reference: what a full scan of the model memory should report.
    function automatic void expect_search(input logic [DW-1:0] k, input logic m,
                                          output int lat, output logic f,
                                          output logic [AW-1:0] p, output logic [AW:0] c);
        f = 1'b0; p = '0; c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (model[i] == k) begin
                if (!f) begin f = 1'b1; p = AW'(i); end
                c = c + 1'b1;
            end
        end
        if (m == MODE_FIRST) begin
            c   = f ? 1 : 0;
            lat = f ? 2 + int'(p) : 1 + DEPTH;
        end else begin
            lat = 1 + DEPTH;
        end
    endfunction

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b0; bus.address = a; bus.din = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
        model[a] = d;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.oe = 1'b1; bus.address = a;
        @(negedge clk);
        bus.cs = 1'b0; bus.oe = 1'b0;
        d = bus.dout;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), '0);
    endtask

    // Launch one search and observe it; inj_n >= 0 drives a host write + start mid-scan.
    task automatic run_search(input logic [DW-1:0] k, input logic m, input bit co_wr,
                              input logic [AW-1:0] co_a, input logic [DW-1:0] co_d,
                              input int inj_n, output int lat, output logic f,
                              output logic [AW-1:0] p, output logic [AW:0] c,
                              output int ndone, output bit busy_ok);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.key = k; bus.mode = m;
        if (co_wr) begin
            bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b0; bus.address = co_a; bus.din = co_d;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.cs = 1'b0; bus.we = 1'b0;
        bus.key = DW'($urandom); bus.mode = 1'($urandom);
        busy_ok = (bus.busy === 1'b1);
        n = 0; lat = -1; ndone = 0; f = 1'bx; p = 'x; c = 'x;
        while (lat < 0 && n < 40) begin
            if (n == inj_n) begin
                bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b0;
                bus.address = 4'd2; bus.din = 8'hEE; bus.start = 1'b1;
            end
            @(negedge clk);
            n++;
            bus.cs = 1'b0; bus.we = 1'b0; bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = n; ndone++;
                f = bus.found; p = bus.position; c = bus.match_count;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.dout, bus.busy, bus.done, bus.found, bus.position, bus.match_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got dout=%h busy=%b done=%b found=%b pos=%0d cnt=%0d, want all 0",
                     bus.dout, bus.busy, bus.done, bus.found, bus.position, bus.match_count);
        end
        rst = 1'b0;
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_host_access();
        logic [DW-1:0] d;
        write_word(4'd3, 8'hA5);
        write_word(4'd4, 8'h5A);
        read_word(4'd3, d);
        checks++;
        if (d !== 8'hA5) begin
            failures++; $display("FAIL host_read: got %h want a5", d);
        end
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b1; bus.address = 4'd4; bus.din = 8'hFF;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b0;
        checks++;
        if (bus.dout !== 8'hA5) begin
            failures++; $display("FAIL noop_dout_hold: got %h want a5", bus.dout);
        end
        read_word(4'd4, d);
        checks++;
        if (d !== model[4]) begin
            failures++; $display("FAIL noop_no_write: got %h want %h", d, model[4]);
        end
        $display("test_host_access: mem[3]=%h mem[4]=%h", 8'hA5, d);
    endtask

    task automatic test_search_mode(input string name, input logic [DW-1:0] k, input logic m,
                                    input bit co_wr, input logic [AW-1:0] co_a,
                                    input logic [DW-1:0] co_d);
        int lat, elat, ndone;
        logic f, ef;
        logic [AW-1:0] p, ep;
        logic [AW:0] c, ec;
        bit busy_ok;
        if (co_wr) model[co_a] = co_d;
        expect_search(k, m, elat, ef, ep, ec);
        run_search(k, m, co_wr, co_a, co_d, -1, lat, f, p, c, ndone, busy_ok);
        checks++;
        if (lat !== elat) begin
            failures++; $display("FAIL %s_latency: got %0d want %0d", name, lat, elat);
        end
        checks++;
        if ({f, p, c} !== {ef, ep, ec}) begin
            failures++;
            $display("FAIL %s_results: got found=%b pos=%0d cnt=%0d want found=%b pos=%0d cnt=%0d",
                     name, f, p, c, ef, ep, ec);
        end
        checks++;
        if (ndone !== 1 || !busy_ok) begin
            failures++; $display("FAIL %s_handshake: got done_pulses=%0d busy_ok=%0b want 1/1", name, ndone, busy_ok);
        end
        checks++;
        if ({bus.found, bus.position, bus.match_count} !== {ef, ep, ec}) begin
            failures++; $display("FAIL %s_hold: got pos=%0d cnt=%0d want pos=%0d cnt=%0d",
                                 name, bus.position, bus.match_count, ep, ec);
        end
        $display("%s: key=%h mode=%0b latency=%0d found=%b pos=%0d cnt=%0d", name, k, m, lat, f, p, c);
    endtask

    task automatic test_search_basic();
        clear_mem();
        write_word(4'd5, 8'h07);
        write_word(4'd9, 8'h07);
        test_search_mode("first_match", 8'h07, MODE_FIRST, 1'b0, '0, '0);
        test_search_mode("count_all", 8'h07, MODE_ALL, 1'b0, '0, '0);
    endtask

    task automatic test_boundary();
        clear_mem();
        write_word(4'd15, 8'h3C);
        test_search_mode("last_addr", 8'h3C, MODE_FIRST, 1'b0, '0, '0);
        test_search_mode("absent", 8'h99, MODE_FIRST, 1'b0, '0, '0);
        test_search_mode("write_with_start", 8'h99, MODE_FIRST, 1'b1, 4'd0, 8'h99);
    endtask

    task automatic test_busy_ignore();
        logic [DW-1:0] d;
        int lat, ndone;
        logic f;
        logic [AW-1:0] p;
        logic [AW:0] c;
        bit busy_ok;
        write_word(4'd2, 8'h11);
        write_word(4'd7, 8'h6B);
        read_word(4'd7, d);
        run_search(8'h42, MODE_ALL, 1'b0, '0, '0, 3, lat, f, p, c, ndone, busy_ok);
        checks++;
        if (lat !== 1 + DEPTH || ndone !== 1) begin
            failures++; $display("FAIL busy_start_ignored: got latency=%0d done_pulses=%0d want %0d/1", lat, ndone, 1 + DEPTH);
        end
        checks++;
        if (bus.dout !== 8'h6B) begin
            failures++; $display("FAIL busy_dout_hold: got %h want 6b", bus.dout);
        end
        read_word(4'd2, d);
        checks++;
        if (d !== 8'h11) begin
            failures++; $display("FAIL busy_write_dropped: got %h want 11", d);
        end
        $display("test_busy_ignore: latency=%0d dones=%0d mem[2]=%h", lat, ndone, d);
    endtask

    task automatic test_reset_mid_scan();
        logic [DW-1:0] d;
        int ndone;
        clear_mem();
        write_word(4'd1, 8'h5C);
        @(negedge clk);
        bus.start = 1'b1; bus.key = 8'h5C; bus.mode = MODE_ALL;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.found !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL midscan_pre: got found=%b busy=%b want 1/1", bus.found, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.dout, bus.busy, bus.done, bus.found, bus.position, bus.match_count} !== '0) begin
            failures++; $display("FAIL midscan_reset: got busy=%b found=%b pos=%0d cnt=%0d want all 0",
                                 bus.busy, bus.found, bus.position, bus.match_count);
        end
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++; $display("FAIL midscan_no_done: got %0d active cycles want 0", ndone);
        end
        read_word(4'd1, d);
        checks++;
        if (d !== 8'h5C) begin
            failures++; $display("FAIL midscan_mem_kept: got %h want 5c", d);
        end
        $display("test_reset_mid_scan: mem[1]=%h after abort", d);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < DEPTH; a++) write_word(AW'(a), DW'($urandom_range(0, 3)));
            test_search_mode("random", DW'($urandom_range(0, 4)), 1'($urandom), 1'b0, '0, '0);
        end
    endtask

    initial begin
        bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b0; bus.address = '0; bus.din = '0;
        bus.start = 1'b0; bus.key = '0; bus.mode = 1'b0;
        test_reset();
        test_host_access();
        test_search_basic();
        test_boundary();
        test_busy_ignore();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
